// File: rtl/pc_pkg.sv
// Shared definitions for the program-counter sequencer: next-PC source
// encodings and the bit positions of the sticky return-stack error flags.
package pc_pkg;

  localparam int PCS_W = 3;

  typedef enum logic [PCS_W-1:0] {
    PCS_INC   = 3'b000,  // pc + 1
    PCS_PAGE  = 3'b001,  // keep page bits, replace offset with ir
    PCS_ABS   = 3'b010,  // absolute jump to a_val
    PCS_CALL  = 3'b011,  // jump to a_val, push pc + 1
    PCS_RET   = 3'b100,  // pop return address
    PCS_REL   = 3'b101,  // pc + 1 + signed ir offset
    PCS_HOLD6 = 3'b110,  // hold, no side effects
    PCS_HOLD7 = 3'b111   // hold, no side effects
  } pc_src_e;

  // Sticky error flag vector layout
  localparam int ERR_OVF = 0;
  localparam int ERR_UNF = 1;
  localparam int ERR_W   = 2;

endpackage

// File: rtl/pc_sequencer_if.sv
// Control/datapath bundle between the instruction decoder and the PC
// sequencer. The master side drives the update controls and operands, the
// slave side (the sequencer) returns the PC and return-stack status.
interface pc_sequencer_if
  import pc_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int RAS_DEPTH = 4
);

  localparam int CNT_W = $clog2(RAS_DEPTH) + 1;

  logic             stall;
  logic             pc_write;
  logic             beq_cond;
  logic             bne_cond;
  logic             zero;
  logic [PCS_W-1:0] pc_source;
  logic [WIDTH-1:0] ir;
  logic [WIDTH-1:0] a_val;
  logic             err_clr;
  logic [WIDTH-1:0] pc;
  logic [CNT_W-1:0] ras_count;
  logic             ras_ovf;
  logic             ras_unf;

  modport master (
    output stall, pc_write, beq_cond, bne_cond, zero, pc_source, ir, a_val, err_clr,
    input  pc, ras_count, ras_ovf, ras_unf
  );

  modport slave (
    input  stall, pc_write, beq_cond, bne_cond, zero, pc_source, ir, a_val, err_clr,
    output pc, ras_count, ras_ovf, ras_unf
  );

endinterface

// File: rtl/pc_ras.sv
// Return-address stack: circular LIFO. A push while full overwrites the
// oldest entry (the write pointer already points at it when full), so the
// newest DEPTH return addresses are always retained.
module pc_ras #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic [WIDTH-1:0]           data_i,
  output logic [WIDTH-1:0]           top_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       full_o,
  output logic                       empty_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_pop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_pop  = pop_i & ~push_i & ~empty_o;

  // Newest entry sits just below the write pointer (wraps modulo DEPTH)
  assign top_o   = mem_q[wr_ptr_q - PTR_W'(1)];
  assign count_o = count_q;

  // Pointer and occupancy next-state; occupancy saturates at DEPTH
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (push_i) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (!full_o) begin
        count_d = count_q + CNT_W'(1);
      end
    end else if (do_pop) begin
      wr_ptr_d = wr_ptr_q - PTR_W'(1);
      count_d  = count_q - CNT_W'(1);
    end
  end

  // Control state: pointer and count, cleared by reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; contents are don't-care after reset
  always_ff @(posedge clk) begin
    if (push_i) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: selects the next PC from increment, page
// branch, absolute, call, return and relative sources, gated by a
// stall-aware update condition, and tracks return-stack error flags.
module pc_sequencer
  import pc_pkg::*;
#(
  parameter int               WIDTH        = 16,
  parameter int               PAGE_W       = 12,
  parameter int               RAS_DEPTH    = 4,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0
) (
  input  logic          clk,
  input  logic          reset,
  pc_sequencer_if.slave bus
);

  localparam int CNT_W = $clog2(RAS_DEPTH) + 1;

  pc_src_e          src;
  logic             upd;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] pc_inc;
  logic [WIDTH-1:0] pc_page;
  logic [WIDTH-1:0] rel_off;
  logic [WIDTH-1:0] pc_rel;
  logic [WIDTH-1:0] ras_top;
  logic [CNT_W-1:0] ras_count;
  logic             ras_push, ras_pop;
  logic             ras_full, ras_empty;
  logic             set_ovf, set_unf;
  logic [ERR_W-1:0] err_q, err_d;
  logic             unused_ir_hi;

  assign src = pc_src_e'(bus.pc_source);

  // Stall overrides every update source; branch enables are qualified by zero
  assign upd = ~bus.stall &
               (bus.pc_write | (bus.beq_cond & bus.zero) | (bus.bne_cond & ~bus.zero));

  // Candidate targets; all sums wrap modulo 2^WIDTH
  assign pc_inc  = pc_q + WIDTH'(1);
  assign pc_page = {pc_q[WIDTH-1:PAGE_W], bus.ir[PAGE_W-1:0]};
  assign rel_off = {{(WIDTH-PAGE_W){bus.ir[PAGE_W-1]}}, bus.ir[PAGE_W-1:0]};
  assign pc_rel  = pc_inc + rel_off;

  // Only the offset field of ir is meaningful here
  assign unused_ir_hi = ^bus.ir[WIDTH-1:PAGE_W];

  // Next-PC mux and return-stack requests; nothing moves unless upd
  always_comb begin
    pc_d     = pc_q;
    ras_push = 1'b0;
    ras_pop  = 1'b0;
    set_ovf  = 1'b0;
    set_unf  = 1'b0;
    if (upd) begin
      case (src)
        PCS_INC:  pc_d = pc_inc;
        PCS_PAGE: pc_d = pc_page;
        PCS_ABS:  pc_d = bus.a_val;
        PCS_CALL: begin
          pc_d     = bus.a_val;
          ras_push = 1'b1;
          set_ovf  = ras_full;
        end
        PCS_RET: begin
          if (ras_empty) begin
            set_unf = 1'b1;
          end else begin
            pc_d    = ras_top;
            ras_pop = 1'b1;
          end
        end
        PCS_REL:  pc_d = pc_rel;
        default:  pc_d = pc_q;
      endcase
    end
  end

  // Sticky flags: err_clr works even while stalled, a same-cycle set wins
  always_comb begin
    err_d = err_q;
    if (bus.err_clr) begin
      err_d = '0;
    end
    if (set_ovf) begin
      err_d[ERR_OVF] = 1'b1;
    end
    if (set_unf) begin
      err_d[ERR_UNF] = 1'b1;
    end
  end

  // PC and error-flag registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q  <= RESET_VECTOR;
      err_q <= '0;
    end else begin
      pc_q  <= pc_d;
      err_q <= err_d;
    end
  end

  pc_ras #(
    .WIDTH (WIDTH),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk     (clk),
    .reset   (reset),
    .push_i  (ras_push),
    .pop_i   (ras_pop),
    .data_i  (pc_inc),
    .top_o   (ras_top),
    .count_o (ras_count),
    .full_o  (ras_full),
    .empty_o (ras_empty)
  );

  assign bus.pc        = pc_q;
  assign bus.ras_count = ras_count;
  assign bus.ras_ovf   = err_q[ERR_OVF];
  assign bus.ras_unf   = err_q[ERR_UNF];

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: reset behaviour, an increment run, then a
// table of single-cycle vectors with hand-computed results, then a
// mid-cycle asynchronous reset sequence.
module tb_pc_sequencer;
  import pc_pkg::*;

  localparam int WIDTH     = 16;
  localparam int RAS_DEPTH = 4;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  pc_sequencer_if #(.WIDTH(WIDTH), .RAS_DEPTH(RAS_DEPTH)) bus ();

  pc_sequencer #(
    .WIDTH        (WIDTH),
    .PAGE_W       (12),
    .RAS_DEPTH    (RAS_DEPTH),
    .RESET_VECTOR (16'h0000)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        stall;
    logic        pw;
    logic        beq;
    logic        bne;
    logic        zero;
    logic        clr;
    logic [2:0]  src;
    logic [15:0] ir;
    logic [15:0] a;
    logic [15:0] exp_pc;
    logic [2:0]  exp_cnt;
    logic        exp_ovf;
    logic        exp_unf;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic add(input logic stall, input logic pw, input logic beq, input logic bne,
                     input logic zero, input logic clr, input logic [2:0] src,
                     input logic [15:0] ir, input logic [15:0] a, input logic [15:0] epc,
                     input logic [2:0] ecnt, input logic eovf, input logic eunf);
    vec_t v;
    v.stall = stall; v.pw = pw; v.beq = beq; v.bne = bne; v.zero = zero; v.clr = clr;
    v.src = src; v.ir = ir; v.a = a;
    v.exp_pc = epc; v.exp_cnt = ecnt; v.exp_ovf = eovf; v.exp_unf = eunf;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic stall, input logic pw, input logic beq, input logic bne,
                       input logic zero, input logic clr, input logic [2:0] src,
                       input logic [15:0] ir, input logic [15:0] a);
    bus.stall     = stall;
    bus.pc_write  = pw;
    bus.beq_cond  = beq;
    bus.bne_cond  = bne;
    bus.zero      = zero;
    bus.err_clr   = clr;
    bus.pc_source = src;
    bus.ir        = ir;
    bus.a_val     = a;
  endtask

  task automatic check_state(input string tag, input logic [15:0] epc, input logic [2:0] ecnt,
                             input logic eovf, input logic eunf);
    check({tag, " pc"},  32'(bus.pc),        32'(epc));
    check({tag, " cnt"}, 32'(bus.ras_count), 32'(ecnt));
    check({tag, " ovf"}, 32'(bus.ras_ovf),   32'(eovf));
    check({tag, " unf"}, 32'(bus.ras_unf),   32'(eunf));
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b0;
    drive(0, 1, 0, 0, 0, 0, PCS_INC, 16'h0000, 16'h0000);

    // Reset state held across edges
    repeat (2) @(posedge clk);
    #1;
    check_state("reset", 16'h0000, 3'd0, 1'b0, 1'b0);

    // Release reset and increment for 11 edges
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 11; i++) begin
      @(posedge clk);
      #1;
      check($sformatf("inc%0d pc", i), 32'(bus.pc), 32'(i + 1));
    end

    //   stall pw beq bne z clr src         ir        a         pc        cnt ovf unf
    add(0, 1, 0, 0, 0, 0, PCS_ABS,  16'h0000, 16'h0006, 16'h0006, 0, 0, 0);
    add(0, 1, 0, 0, 0, 0, PCS_ABS,  16'h0000, 16'h0005, 16'h0005, 0, 0, 0);
    add(0, 1, 0, 0, 0, 0, PCS_INC,  16'h0000, 16'h0000, 16'h0006, 0, 0, 0);
    add(0, 1, 0, 0, 0, 0, PCS_ABS,  16'h0000, 16'h1003, 16'h1003, 0, 0, 0);
    add(0, 0, 1, 0, 1, 0, PCS_PAGE, 16'hFFC5, 16'h0000, 16'h1FC5, 0, 0, 0);
    add(0, 0, 1, 0, 0, 0, PCS_PAGE, 16'hFFC5, 16'h0000, 16'h1FC5, 0, 0, 0);
    add(0, 0, 0, 1, 0, 0, PCS_INC,  16'h0000, 16'h0000, 16'h1FC6, 0, 0, 0);
    add(0, 0, 0, 1, 1, 0, PCS_INC,  16'h0000, 16'h0000, 16'h1FC6, 0, 0, 0);
    add(0, 1, 0, 0, 0, 0, PCS_ABS,  16'h0000, 16'h0010, 16'h0010, 0, 0, 0);
    add(0, 1, 0, 0, 0, 0, PCS_REL,  16'h0FFE, 16'h0000, 16'h000F, 0, 0, 0);
    add(0, 1, 0, 0, 0, 0, PCS_ABS,  16'h0000, 16'hFFFF, 16'hFFFF, 0, 0, 0);
    add(0, 1, 0, 0, 0, 0, PCS_INC,  16'h0000, 16'h0000, 16'h0000, 0, 0, 0);
    add(0, 1, 0, 0, 0, 0, 3'b110,   16'h0000, 16'h1234, 16'h0000, 0, 0, 0);
    add(0, 1, 0, 0, 0, 0, 3'b111,   16'h0000, 16'h1234, 16'h0000, 0, 0, 0);
    add(0, 1, 0, 0, 0, 0, PCS_ABS,  16'h0000, 16'h0020, 16'h0020, 0, 0, 0);
    add(0, 1, 0, 0, 0, 0, PCS_CALL, 16'h0000, 16'h0100, 16'h0100, 1, 0, 0);
    add(0, 1, 0, 0, 0, 0, PCS_CALL, 16'h0000, 16'h0101, 16'h0101, 2, 0, 0);
    add(0, 1, 0, 0, 0, 0, PCS_CALL, 16'h0000, 16'h0102, 16'h0102, 3, 0, 0);
    add(0, 1, 0, 0, 0, 0, PCS_CALL, 16'h0000, 16'h0103, 16'h0103, 4, 0, 0);
    add(0, 1, 0, 0, 0, 0, PCS_CALL, 16'h0000, 16'h0104, 16'h0104, 4, 1, 0);
    add(0, 1, 0, 0, 0, 0, PCS_RET,  16'h0000, 16'h0000, 16'h0104, 3, 1, 0);
    add(0, 1, 0, 0, 0, 0, PCS_RET,  16'h0000, 16'h0000, 16'h0103, 2, 1, 0);
    add(0, 1, 0, 0, 0, 0, PCS_RET,  16'h0000, 16'h0000, 16'h0102, 1, 1, 0);
    add(0, 1, 0, 0, 0, 0, PCS_RET,  16'h0000, 16'h0000, 16'h0101, 0, 1, 0);
    add(0, 1, 0, 0, 0, 0, PCS_RET,  16'h0000, 16'h0000, 16'h0101, 0, 1, 1);
    add(1, 1, 0, 0, 0, 1, PCS_INC,  16'h0000, 16'h0000, 16'h0101, 0, 0, 0);
    add(1, 1, 0, 0, 0, 0, PCS_CALL, 16'h0000, 16'h0300, 16'h0101, 0, 0, 0);
    add(0, 1, 0, 0, 0, 0, PCS_CALL, 16'h0000, 16'h0200, 16'h0200, 1, 0, 0);
    add(0, 1, 0, 0, 0, 0, PCS_RET,  16'h0000, 16'h0000, 16'h0102, 0, 0, 0);
    add(0, 1, 0, 0, 0, 1, PCS_RET,  16'h0000, 16'h0000, 16'h0102, 0, 0, 1);
    add(0, 0, 1, 0, 0, 0, PCS_CALL, 16'h0000, 16'h0300, 16'h0102, 0, 0, 1);
    add(0, 0, 0, 0, 0, 1, PCS_INC,  16'h0000, 16'h0000, 16'h0102, 0, 0, 0);
    add(0, 0, 0, 1, 0, 0, PCS_CALL, 16'h0000, 16'h0300, 16'h0300, 1, 0, 0);
    add(0, 0, 1, 0, 1, 0, PCS_RET,  16'h0000, 16'h0000, 16'h0103, 0, 0, 0);

    foreach (vecs[i]) begin
      drive(vecs[i].stall, vecs[i].pw, vecs[i].beq, vecs[i].bne, vecs[i].zero,
            vecs[i].clr, vecs[i].src, vecs[i].ir, vecs[i].a);
      @(posedge clk);
      #1;
      check_state($sformatf("vec%0d", i), vecs[i].exp_pc, vecs[i].exp_cnt,
                  vecs[i].exp_ovf, vecs[i].exp_unf);
    end

    // Mid-cycle asynchronous reset while a CALL is pending
    drive(0, 1, 0, 0, 0, 0, PCS_CALL, 16'h0000, 16'h0400);
    @(posedge clk);
    #1;
    check_state("call400", 16'h0400, 3'd1, 1'b0, 1'b0);
    drive(0, 1, 0, 0, 0, 0, PCS_CALL, 16'h0000, 16'h0500);
    #2;
    reset = 1'b0;
    #1;
    check_state("async_rst", 16'h0000, 3'd0, 1'b0, 1'b0);
    drive(0, 1, 0, 0, 0, 0, PCS_INC, 16'h0000, 16'h0000);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check_state("post_rst", 16'h0001, 3'd0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
